// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: tracks in-flight destinations for E/M/W(...) and
// produces hold/bubble/flush controls for the F/D/E pipeline registers
// plus operand-forwarding selects for Execute. Covers load-use stalls,
// multi-cycle Execute ops and a configurable taken-branch squash window.
// This block has no valid/ready handshakes; "enable" is a global advance
// qualifier that freezes all state when low.
module hazard_ctrl_unit #(
  parameter int AW       = 4,
  parameter int DEPTH    = 3,
  parameter int MC_LAT   = 4,
  parameter int BR_FLUSH = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [AW-1:0]            src1D,
  input  logic [AW-1:0]            src2D,
  input  logic                     src1_useD,
  input  logic                     src2_useD,
  input  logic [AW-1:0]            destD,
  input  logic                     regwriteD,
  input  logic                     loadD,
  input  logic                     multicycleD,
  input  logic                     branch_takenD,
  output logic                     stall_fd,
  output logic                     hold_e,
  output logic                     bubble_e,
  output logic                     flush_d,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] fwd1E,
  output logic [$clog2(DEPTH)-1:0] fwd2E
);

  localparam int FW = $clog2(DEPTH);

  // One tracked pipeline slot. Source fields only matter in stage 0 (E).
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] dest;
    logic          regwrite;
    logic          load;
    logic [AW-1:0] src1;
    logic [AW-1:0] src2;
    logic          src1_use;
    logic          src2_use;
  } entry_t;

  entry_t     stage_q [DEPTH];
  entry_t     stage_d [DEPTH];
  entry_t     d_entry;
  logic [3:0] mc_cnt_q, mc_cnt_d;
  logic [1:0] fl_cnt_q, fl_cnt_d;
  logic       mc;
  logic       lu;

  // Address comparison; register 0 is hardwired and never matches when ZERO_REG is set.
  function automatic logic addr_match(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (a == b) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Package the Decode instruction; it is squashed while a flush window is open.
  always_comb begin
    d_entry          = '0;
    d_entry.valid    = (fl_cnt_q == 2'd0);
    d_entry.dest     = destD;
    d_entry.regwrite = regwriteD;
    d_entry.load     = loadD;
    d_entry.src1     = src1D;
    d_entry.src2     = src2D;
    d_entry.src1_use = src1_useD;
    d_entry.src2_use = src2_useD;
  end

  // Hazard detection: multi-cycle occupancy masks load-use.
  always_comb begin
    mc = (mc_cnt_q != 4'd0);
    lu = !mc && d_entry.valid && stage_q[0].valid && stage_q[0].load && stage_q[0].regwrite &&
         ((src1_useD && addr_match(src1D, stage_q[0].dest)) ||
          (src2_useD && addr_match(src2D, stage_q[0].dest)));
  end

  // Pipeline control outputs.
  always_comb begin
    busy     = mc;
    hold_e   = mc;
    stall_fd = mc | lu;
    bubble_e = lu;
    flush_d  = (fl_cnt_q != 2'd0);
  end

  // Forward select: scan oldest to youngest so the youngest producer overrides.
  always_comb begin
    fwd1E = '0;
    fwd2E = '0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (stage_q[0].valid && stage_q[0].src1_use && stage_q[k].valid && stage_q[k].regwrite &&
          addr_match(stage_q[k].dest, stage_q[0].src1))
        fwd1E = FW'(k);
      if (stage_q[0].valid && stage_q[0].src2_use && stage_q[k].valid && stage_q[k].regwrite &&
          addr_match(stage_q[k].dest, stage_q[0].src2))
        fwd2E = FW'(k);
    end
  end

  // Next-state: stage shifting, multi-cycle counter and branch window.
  always_comb begin
    stage_d  = stage_q;
    mc_cnt_d = mc_cnt_q;
    fl_cnt_d = fl_cnt_q;
    if (enable) begin
      if (mc) begin
        // E holds the long op; a bubble flows out behind it.
        mc_cnt_d   = mc_cnt_q - 4'd1;
        stage_d[1] = '0;
        for (int k = 2; k < DEPTH; k++) stage_d[k] = stage_q[k-1];
      end else begin
        stage_d[0] = lu ? '0 : d_entry;
        for (int k = 1; k < DEPTH; k++) stage_d[k] = stage_q[k-1];
        if (!lu && d_entry.valid && multicycleD && (MC_LAT > 1))
          mc_cnt_d = 4'(MC_LAT - 1);
      end
      // A branch seen while stalled or squashed is replayed or wrong-path, so it is ignored.
      if ((fl_cnt_q != 2'd0) && !stall_fd)
        fl_cnt_d = fl_cnt_q - 2'd1;
      else if (!stall_fd && (fl_cnt_q == 2'd0) && branch_takenD)
        fl_cnt_d = 2'(BR_FLUSH);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
      mc_cnt_q <= 4'd0;
      fl_cnt_q <= 2'd0;
    end else begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= stage_d[k];
      mc_cnt_q <= mc_cnt_d;
      fl_cnt_q <= fl_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit (DEPTH=3, MC_LAT=4, BR_FLUSH=2, ZERO_REG=1).
module tb_hazard_ctrl_unit;

  localparam int AW = 4;
  localparam int DEPTH = 3;
  localparam int FW = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [AW-1:0] src1D, src2D, destD;
  logic          src1_useD, src2_useD, regwriteD, loadD, multicycleD, branch_takenD;
  logic          stall_fd, hold_e, bubble_e, flush_d, busy;
  logic [FW-1:0] fwd1E, fwd2E;

  int n_checks = 0;
  int n_errors = 0;

  hazard_ctrl_unit #(
    .AW(AW), .DEPTH(DEPTH), .MC_LAT(4), .BR_FLUSH(2), .ZERO_REG(1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .src1D(src1D), .src2D(src2D), .src1_useD(src1_useD), .src2_useD(src2_useD),
    .destD(destD), .regwriteD(regwriteD), .loadD(loadD), .multicycleD(multicycleD),
    .branch_takenD(branch_takenD),
    .stall_fd(stall_fd), .hold_e(hold_e), .bubble_e(bubble_e), .flush_d(flush_d),
    .busy(busy), .fwd1E(fwd1E), .fwd2E(fwd2E)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input logic [3:0] s1, input logic u1, input logic [3:0] s2, input logic u2,
                         input logic [3:0] dst, input logic rw, input logic ld, input logic mcop,
                         input logic br);
    src1D = s1; src1_useD = u1; src2D = s2; src2_useD = u2;
    destD = dst; regwriteD = rw; loadD = ld; multicycleD = mcop; branch_takenD = br;
    #1;
  endtask

  task automatic nop();
    drive_d(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    nop();
    repeat (4) tick();
  endtask

  task automatic chk_ctl(input string tag, input logic s, input logic h, input logic b,
                         input logic f, input logic bz);
    chk({tag, ".stall_fd"}, {3'd0, stall_fd}, {3'd0, s});
    chk({tag, ".hold_e"},   {3'd0, hold_e},   {3'd0, h});
    chk({tag, ".bubble_e"}, {3'd0, bubble_e}, {3'd0, b});
    chk({tag, ".flush_d"},  {3'd0, flush_d},  {3'd0, f});
    chk({tag, ".busy"},     {3'd0, busy},     {3'd0, bz});
  endtask

  task automatic chk_fwd(input string tag, input logic [1:0] f1, input logic [1:0] f2);
    chk({tag, ".fwd1E"}, {2'd0, fwd1E}, {2'd0, f1});
    chk({tag, ".fwd2E"}, {2'd0, fwd2E}, {2'd0, f2});
  endtask

  initial begin
    // ---- reset with random D inputs ----
    reset = 1'b0;
    enable = 1'($urandom_range(0, 1));
    drive_d(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    tick();
    drive_d(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    tick();
    reset = 1'b1;
    enable = 1'b1;
    nop();
    chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_fwd("reset", 2'd0, 2'd0);

    // ---- load-use: load r3 then consumer of r3 on src1 ----
    drive_d(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_ctl("lu_load_in_d", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive_d(4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_ctl("lu_stall", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_ctl("lu_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_fwd("lu_bubble_in_e", 2'd0, 2'd0);
    tick();
    nop();
    chk_fwd("lu_consumer_e", 2'd2, 2'd0);

    // ---- load-use control: src1 not used ----
    drain();
    drive_d(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive_d(4'd3, 1'b0, 4'd7, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_ctl("lu_nouse", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    nop();
    chk_fwd("lu_nouse_e", 2'd0, 2'd0);

    // ---- forward priority: r5 written in stages 1 and 2 ----
    drain();
    drive_d(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    drive_d(4'd0, 1'b0, 4'd5, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_ctl("fwd_alu_no_stall", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    nop();
    chk_fwd("fwd_youngest", 2'd0, 2'd1);

    // ---- zero register: load r0 then consumer of r0 ----
    drain();
    drive_d(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive_d(4'd0, 1'b1, 4'd0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_ctl("zero_no_lu", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    nop();
    chk_fwd("zero_no_fwd", 2'd0, 2'd0);

    // ---- multi-cycle op reading r9, bubbles visible through forwarding ----
    drain();
    drive_d(4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive_d(4'd9, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    chk_ctl("mc_in_d", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive_d(4'd6, 1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_ctl("mc_busy1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_fwd("mc_busy1", 2'd1, 2'd0);
    tick();
    chk_ctl("mc_busy2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_fwd("mc_busy2", 2'd2, 2'd0);
    tick();
    chk_ctl("mc_busy3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_fwd("mc_busy3", 2'd0, 2'd0);
    tick();
    chk_ctl("mc_last", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    nop();
    chk_fwd("mc_consumer_e", 2'd1, 2'd0);

    // ---- multi-cycle with enable low for 2 cycles ----
    drain();
    drive_d(4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    nop();
    chk_ctl("mce_b1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk_ctl("mce_b2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    enable = 1'b0;
    tick();
    chk_ctl("mce_frz1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk_ctl("mce_frz2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    enable = 1'b1;
    tick();
    chk_ctl("mce_b5", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk_ctl("mce_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // ---- branch flush window of 2, branch held high inside the window ----
    drain();
    drive_d(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_ctl("br_in_d", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive_d(4'd0, 1'b0, 4'd0, 1'b0, 4'd10, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_ctl("br_win1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_ctl("br_win2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive_d(4'd10, 1'b1, 4'd0, 1'b0, 4'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_ctl("br_closed", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    nop();
    chk_fwd("br_squashed_invalid", 2'd0, 2'd0);

    // ---- priority: taken branch in D during multi-cycle op ----
    drain();
    drive_d(4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    drive_d(4'd2, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_ctl("col_b1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk_ctl("col_b2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk_ctl("col_b3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk_ctl("col_release", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    nop();
    chk_ctl("col_win1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_ctl("col_win2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_ctl("col_win_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // ---- reset asserted mid multi-cycle op ----
    drain();
    drive_d(4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    nop();
    chk_ctl("rst_mid_busy", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk_ctl("rst_mid_clear", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
